gshare_fetch_predictor: RTL and testbench
=========================================

Name: gshare_fetch_predictor

Overview:
Fetch-stage front end that sits directly upstream of the IF/ID pipeline register. It owns the program counter, a gshare pattern history table (PHT) indexed by PC xor the global history register (GHR), and a direct-mapped branch target buffer (BTB). Each cycle it presents the fetch PC to instruction memory and produces the instruction, the prediction, the predicted target, the next PC and the predictor bookkeeping indices that the IF/ID register latches. The EX stage retrains it and redirects it on a mispredict.

Parameters:
HIST_BITS, 5, width of the GHR, PHT index and BTB index (32 entries each)
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  clock
Reset  in  1  reset
PC_write  in  1  1 = advance PC; 0 = hold PC and GHR (stall)
imem_inst  in  32  instruction read combinationally at pc_out
pc_out  out  32  current fetch PC to instruction memory
IF_inst  out  32  equals imem_inst
nextPC  out  32  pc_out + 4, mod 2^32
prediction  out  1  1 = predicted taken
branch_target  out  32  BTB target for pc_out (0 on miss)
updated_pc_IF  out  32  prediction ? branch_target : nextPC
GHPT_index_IF  out  5  pc_out[6:2] ^ GHR
GHR_IF  out  5  GHR value used for this prediction
G_BTB_index_IF  out  5  pc_out[6:2]
ex_valid  in  1  resolved branch update valid this cycle
ex_taken  in  1  actual branch outcome
ex_target  in  32  actual taken target
ex_pc  in  32  PC of the resolved branch
ex_GHPT_index  in  5  PHT index carried down the pipe
ex_G_BTB_index  in  5  BTB index carried down the pipe
ex_GHR  in  5  GHR snapshot carried down the pipe
ex_mispredict  in  1  redirect required (qualified by ex_valid)
ex_correct_pc  in  32  redirect address

Behaviour:
- Reset is asynchronous and active-high. Reset loads PC to RESET_PC and GHR to 0, sets all 32 PHT counters to 2'b01 (weakly not-taken), and clears all BTB valid bits.
- Outputs after reset: pc_out = RESET_PC, nextPC = RESET_PC+4, prediction = 0, branch_target = 0, updated_pc_IF = RESET_PC+4, GHR_IF = 0.
- Prediction is combinational from the current PC/GHR, so it has zero-cycle latency.
- A BTB entry holds valid, tag = pc[31:7] and target. hit = valid[pc[6:2]] and tag match.
- prediction = hit AND PHT[GHPT_index_IF][1]. On a miss, branch_target = 0 and prediction = 0.
- Sequential update priority on each clk edge:
  1. ex_valid & ex_mispredict: PC <= ex_correct_pc and GHR <= {ex_GHR[3:0], ex_taken}. This applies regardless of PC_write.
  2. Otherwise, if PC_write: PC <= updated_pc_IF. If hit, also GHR <= {GHR[3:0], prediction} (speculative shift). On a miss GHR is unchanged.
  3. Otherwise PC and GHR hold.
- Training on ex_valid:
  - PHT[ex_GHPT_index] saturates up on ex_taken and down otherwise, clamped at 2'b11 and 2'b00.
  - If ex_taken, BTB[ex_G_BTB_index] <= {valid=1, tag=ex_pc[31:7], target=ex_target}.
  - Not-taken outcomes leave the BTB unchanged.
- Training is independent of PC_write, so it still occurs during a stall.
- Read/write collision on the same index in the same cycle: the combinational read returns the old value, and the new value is visible from the next cycle.
- ex_mispredict without ex_valid is ignored.
- PC arithmetic wraps: 32'hFFFF_FFFC + 4 = 0.
- Reset asserted mid-operation overrides all pending updates immediately.

Test Plan:
- Reset: assert Reset mid-run -> pc_out = 0, nextPC = 4, prediction = 0, GHR_IF = 0, updated_pc_IF = 4; PHT reads 01 at every index.
- Sequential fetch: PC_write = 1 for 4 cycles with no BTB hits -> pc_out = 0, 4, 8, 12; GHR stays 0; G_BTB_index_IF = 0, 1, 2, 3.
- Train and predict:
  - Stimulus: ex_valid with ex_taken = 1, ex_pc = 0x10, ex_target = 0x40, ex_GHPT_index = 4, ex_G_BTB_index = 4, no mispredict.
  - Then redirect the PC to 0x10 with GHR = 0.
  - Required: prediction = 1, branch_target = 0x40, updated_pc_IF = 0x40.
  - On the next edge with PC_write = 1: pc_out = 0x40 and GHR = 5'b00001.
- Mispredict recovery: GHR speculatively 5'b10110; apply ex_valid & ex_mispredict with ex_GHR = 5'b00011, ex_taken = 0, ex_correct_pc = 0x88, PC_write = 0 -> next cycle pc_out = 0x88, GHR_IF = 5'b00110.
- Stall: PC_write = 0 for 3 cycles at pc_out = 0x20 -> pc_out stays 0x20 and GHR unchanged; a concurrent ex_valid update still changes PHT/BTB.
- Saturation and collision:
  - Five taken updates at index 7 -> counter reaches 11 and stays 11; five not-taken updates -> counter reaches 00 and stays 00.
  - Update index 4 while fetching at index 4 -> the old prediction shows in that cycle and the new one in the next.

Source files
------------

// File: rtl/gshare_fetch_predictor.sv
// Fetch-stage front end: owns the PC, a gshare PHT (pc index xor GHR) and a
// direct-mapped BTB. Prediction is combinational from the current PC/GHR.
// The EX stage trains both tables and redirects the PC on a mispredict.
module gshare_fetch_predictor #(
    parameter int          HIST_BITS = 5,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 PC_write,
    input  logic [31:0]          imem_inst,
    output logic [31:0]          pc_out,
    output logic [31:0]          IF_inst,
    output logic [31:0]          nextPC,
    output logic                 prediction,
    output logic [31:0]          branch_target,
    output logic [31:0]          updated_pc_IF,
    output logic [HIST_BITS-1:0] GHPT_index_IF,
    output logic [HIST_BITS-1:0] GHR_IF,
    output logic [HIST_BITS-1:0] G_BTB_index_IF,
    input  logic                 ex_valid,
    input  logic                 ex_taken,
    input  logic [31:0]          ex_target,
    input  logic [31:0]          ex_pc,
    input  logic [HIST_BITS-1:0] ex_GHPT_index,
    input  logic [HIST_BITS-1:0] ex_G_BTB_index,
    input  logic [HIST_BITS-1:0] ex_GHR,
    input  logic                 ex_mispredict,
    input  logic [31:0]          ex_correct_pc
);

    localparam int ENTRIES = 1 << HIST_BITS;
    localparam int TAG_LSB = HIST_BITS + 2;
    localparam int TAG_W   = 32 - TAG_LSB;

    logic [31:0]                     pc_q, pc_d;
    logic [HIST_BITS-1:0]            ghr_q, ghr_d;
    logic [ENTRIES-1:0][1:0]         pht_q, pht_d;
    logic [ENTRIES-1:0]              btb_vld_q, btb_vld_d;
    logic [ENTRIES-1:0][TAG_W-1:0]   btb_tag_q, btb_tag_d;
    logic [ENTRIES-1:0][31:0]        btb_tgt_q, btb_tgt_d;

    logic [HIST_BITS-1:0] btb_idx;
    logic [HIST_BITS-1:0] pht_idx;
    logic                 hit;
    logic [1:0]           ex_cnt;

    // Low PC bits of the resolved branch are covered by the index, and the
    // oldest history bit of the snapshot is shifted out on recovery.
    logic unused_ok;
    assign unused_ok = ^{ex_pc[TAG_LSB-1:0], ex_GHR[HIST_BITS-1]};

    // Combinational lookup: reads always see the pre-edge table contents,
    // so a same-index update becomes visible only on the following cycle.
    assign btb_idx        = pc_q[TAG_LSB-1:2];
    assign pht_idx        = btb_idx ^ ghr_q;
    assign hit            = btb_vld_q[btb_idx] && (btb_tag_q[btb_idx] == pc_q[31:TAG_LSB]);
    assign prediction     = hit && pht_q[pht_idx][1];
    assign branch_target  = hit ? btb_tgt_q[btb_idx] : 32'd0;
    assign nextPC         = pc_q + 32'd4;
    assign updated_pc_IF  = prediction ? branch_target : nextPC;
    assign pc_out         = pc_q;
    assign IF_inst        = imem_inst;
    assign GHPT_index_IF  = pht_idx;
    assign GHR_IF         = ghr_q;
    assign G_BTB_index_IF = btb_idx;

    // PC/GHR next state: EX redirect beats stall; speculative GHR shift only on a BTB hit.
    always_comb begin
        pc_d  = pc_q;
        ghr_d = ghr_q;
        if (ex_valid && ex_mispredict) begin
            pc_d  = ex_correct_pc;
            ghr_d = {ex_GHR[HIST_BITS-2:0], ex_taken};
        end else if (PC_write) begin
            pc_d = updated_pc_IF;
            if (hit) begin
                ghr_d = {ghr_q[HIST_BITS-2:0], prediction};
            end
        end
    end

    // Table training from EX: saturating PHT counter, BTB fill on taken only.
    always_comb begin
        pht_d     = pht_q;
        btb_vld_d = btb_vld_q;
        btb_tag_d = btb_tag_q;
        btb_tgt_d = btb_tgt_q;
        ex_cnt    = pht_q[ex_GHPT_index];
        if (ex_valid) begin
            if (ex_taken) begin
                if (ex_cnt != 2'b11) pht_d[ex_GHPT_index] = ex_cnt + 2'd1;
                btb_vld_d[ex_G_BTB_index] = 1'b1;
                btb_tag_d[ex_G_BTB_index] = ex_pc[31:TAG_LSB];
                btb_tgt_d[ex_G_BTB_index] = ex_target;
            end else if (ex_cnt != 2'b00) begin
                pht_d[ex_GHPT_index] = ex_cnt - 2'd1;
            end
        end
    end

    // Architectural state with async reset: PC, GHR, PHT counters, BTB valids.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            pc_q      <= RESET_PC;
            ghr_q     <= '0;
            pht_q     <= {ENTRIES{2'b01}};
            btb_vld_q <= '0;
        end else begin
            pc_q      <= pc_d;
            ghr_q     <= ghr_d;
            pht_q     <= pht_d;
            btb_vld_q <= btb_vld_d;
        end
    end

    // BTB payload needs no reset; it is qualified by the valid bits.
    always_ff @(posedge clk) begin
        btb_tag_q <= btb_tag_d;
        btb_tgt_q <= btb_tgt_d;
    end

endmodule

// File: tb/tb_gshare_fetch_predictor.sv
// Directed bench for gshare_fetch_predictor: table-driven sequential fetch
// plus hand-written sequences for training, recovery, stall, saturation,
// collision, mid-run reset and PC wrap.
module tb_gshare_fetch_predictor;

    logic        clk = 1'b0;
    logic        Reset;
    logic        PC_write;
    logic [31:0] imem_inst;
    logic [31:0] pc_out, IF_inst, nextPC, branch_target, updated_pc_IF;
    logic        prediction;
    logic [4:0]  GHPT_index_IF, GHR_IF, G_BTB_index_IF;
    logic        ex_valid, ex_taken, ex_mispredict;
    logic [31:0] ex_target, ex_pc, ex_correct_pc;
    logic [4:0]  ex_GHPT_index, ex_G_BTB_index, ex_GHR;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        pc_write;
        logic [31:0] exp_pc;
        logic [4:0]  exp_idx;
        logic [4:0]  exp_ghr;
    } vec_t;

    vec_t seq_tab [4];

    gshare_fetch_predictor #(.HIST_BITS(5), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .Reset(Reset), .PC_write(PC_write), .imem_inst(imem_inst),
        .pc_out(pc_out), .IF_inst(IF_inst), .nextPC(nextPC), .prediction(prediction),
        .branch_target(branch_target), .updated_pc_IF(updated_pc_IF),
        .GHPT_index_IF(GHPT_index_IF), .GHR_IF(GHR_IF), .G_BTB_index_IF(G_BTB_index_IF),
        .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_target(ex_target), .ex_pc(ex_pc),
        .ex_GHPT_index(ex_GHPT_index), .ex_G_BTB_index(ex_G_BTB_index), .ex_GHR(ex_GHR),
        .ex_mispredict(ex_mispredict), .ex_correct_pc(ex_correct_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ex();
        ex_valid = 0; ex_taken = 0; ex_mispredict = 0;
        ex_target = 0; ex_pc = 0; ex_correct_pc = 0;
        ex_GHPT_index = 0; ex_G_BTB_index = 0; ex_GHR = 0;
    endtask

    // Redirect PC to addr with resulting GHR g (g[0] must be 0: uses a not-taken
    // outcome, training only the otherwise unused PHT slot 31).
    task automatic redirect(input logic [31:0] addr, input logic [4:0] g);
        ex_valid = 1; ex_mispredict = 1; ex_taken = g[0];
        ex_GHR = {1'b0, g[4:1]}; ex_correct_pc = addr;
        ex_GHPT_index = 5'd31; ex_G_BTB_index = 5'd31; ex_pc = 0; ex_target = 0;
        PC_write = 0;
        step();
        idle_ex();
    endtask

    task automatic train(input logic tk, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic [4:0] pidx, input logic [4:0] bidx);
        ex_valid = 1; ex_mispredict = 0; ex_taken = tk;
        ex_pc = pc; ex_target = tgt; ex_GHPT_index = pidx; ex_G_BTB_index = bidx;
    endtask

    initial begin
        seq_tab[0] = '{1'b1, 32'd0,  5'd0, 5'd0};
        seq_tab[1] = '{1'b1, 32'd4,  5'd1, 5'd0};
        seq_tab[2] = '{1'b1, 32'd8,  5'd2, 5'd0};
        seq_tab[3] = '{1'b1, 32'd12, 5'd3, 5'd0};

        Reset = 1; PC_write = 0; imem_inst = 32'hA5A5_1234;
        idle_ex();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_next", nextPC, 32'h4);
        chk("rst_pred", {31'd0, prediction}, 32'd0);
        chk("rst_tgt", branch_target, 32'h0);
        chk("rst_upd", updated_pc_IF, 32'h4);
        chk("rst_ghr", {27'd0, GHR_IF}, 32'd0);
        chk("if_inst", IF_inst, 32'hA5A5_1234);
        Reset = 0;

        // sequential fetch, no BTB hits
        for (int i = 0; i < 4; i++) begin
            chk("seq_pc", pc_out, seq_tab[i].exp_pc);
            chk("seq_btbidx", {27'd0, G_BTB_index_IF}, {27'd0, seq_tab[i].exp_idx});
            chk("seq_ghr", {27'd0, GHR_IF}, {27'd0, seq_tab[i].exp_ghr});
            chk("seq_pred", {31'd0, prediction}, 32'd0);
            PC_write = seq_tab[i].pc_write;
            step();
        end
        PC_write = 0;

        // train then predict at 0x10
        train(1, 32'h10, 32'h40, 5'd4, 5'd4);
        step();
        idle_ex();
        redirect(32'h10, 5'd0);
        chk("tp_pc", pc_out, 32'h10);
        chk("tp_pred", {31'd0, prediction}, 32'd1);
        chk("tp_tgt", branch_target, 32'h40);
        chk("tp_upd", updated_pc_IF, 32'h40);
        PC_write = 1;
        step();
        PC_write = 0;
        chk("tp_pc2", pc_out, 32'h40);
        chk("tp_ghr2", {27'd0, GHR_IF}, 32'd1);

        // collision: PHT[4] 10 -> 01 while fetching at index 4
        redirect(32'h10, 5'd0);
        train(0, 32'h10, 32'h0, 5'd4, 5'd4);
        #1;
        chk("coll_old", {31'd0, prediction}, 32'd1);
        step();
        idle_ex();
        chk("coll_new", {31'd0, prediction}, 32'd0);

        // mispredict recovery
        redirect(32'h300, 5'b10110);
        chk("mp_spec_ghr", {27'd0, GHR_IF}, {27'd0, 5'b10110});
        ex_valid = 1; ex_mispredict = 1; ex_taken = 0; ex_GHR = 5'b00011;
        ex_correct_pc = 32'h88; ex_GHPT_index = 5'd31; PC_write = 0;
        step();
        idle_ex();
        chk("mp_pc", pc_out, 32'h88);
        chk("mp_ghr", {27'd0, GHR_IF}, {27'd0, 5'b00110});
        ex_mispredict = 1; ex_correct_pc = 32'h500;
        step();
        idle_ex();
        chk("mp_novalid", pc_out, 32'h88);

        // stall at 0x20 with concurrent training
        redirect(32'h20, 5'd0);
        for (int i = 0; i < 3; i++) begin
            train(1, 32'h20, 32'h100, 5'd8, 5'd8);
            PC_write = 0;
            step();
            chk("stall_pc", pc_out, 32'h20);
            chk("stall_ghr", {27'd0, GHR_IF}, 32'd0);
        end
        idle_ex();
        chk("stall_pred", {31'd0, prediction}, 32'd1);
        chk("stall_tgt", branch_target, 32'h100);
        PC_write = 1;
        step();
        PC_write = 0;
        chk("stall_go_pc", pc_out, 32'h100);
        chk("stall_go_ghr", {27'd0, GHR_IF}, 32'd1);

        // saturation at index 7
        redirect(32'h1C, 5'd0);
        for (int i = 0; i < 5; i++) begin
            train(1, 32'h1C, 32'h200, 5'd7, 5'd7);
            step();
        end
        idle_ex();
        chk("sat_up", {31'd0, prediction}, 32'd1);
        train(0, 32'h1C, 32'h0, 5'd7, 5'd7);
        step();
        chk("sat_dn1", {31'd0, prediction}, 32'd1);
        step();
        chk("sat_dn2", {31'd0, prediction}, 32'd0);
        repeat (3) step();
        idle_ex();
        chk("sat_dn5", {31'd0, prediction}, 32'd0);
        train(1, 32'h1C, 32'h200, 5'd7, 5'd7);
        step();
        idle_ex();
        chk("sat_lo_up1", {31'd0, prediction}, 32'd0);
        train(1, 32'h1C, 32'h200, 5'd7, 5'd7);
        step();
        idle_ex();
        chk("sat_lo_up2", {31'd0, prediction}, 32'd1);

        // mid-run reset overrides pending updates
        PC_write = 1;
        train(1, 32'h1C, 32'h200, 5'd7, 5'd7);
        #3 Reset = 1;
        #1;
        chk("mrst_pc", pc_out, 32'h0);
        chk("mrst_next", nextPC, 32'h4);
        chk("mrst_pred", {31'd0, prediction}, 32'd0);
        chk("mrst_upd", updated_pc_IF, 32'h4);
        chk("mrst_ghr", {27'd0, GHR_IF}, 32'd0);
        step();
        chk("mrst_hold_pc", pc_out, 32'h0);
        Reset = 0;
        PC_write = 0;
        idle_ex();

        // PHT[7] must be back at 01: BTB hit but predicted not-taken
        train(1, 32'h1C, 32'h200, 5'd31, 5'd7);
        step();
        idle_ex();
        redirect(32'h1C, 5'd0);
        chk("pht_rst_tgt", branch_target, 32'h200);
        chk("pht_rst_pred", {31'd0, prediction}, 32'd0);

        // PC wrap
        redirect(32'hFFFF_FFFC, 5'd0);
        chk("wrap_next", nextPC, 32'h0);
        chk("wrap_upd", updated_pc_IF, 32'h0);
        PC_write = 1;
        step();
        PC_write = 0;
        chk("wrap_pc", pc_out, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
